// File: rtl/divider_pkg.sv
// Shared declarations for the restoring divider.
//   state_t   : control FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_N : default operand/result width in bits
package divider_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_datapath.sv
// Restoring shift-subtract datapath: partial remainder A (N+1 bits),
// quotient shift register Q (N bits), divisor register M (N bits).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   do_init           : load A<=0, Q<=dividend, M<=divisor
//   do_shift          : perform one shift/trial-subtract iteration
//   dividend, divisor : operands, sampled when do_init is high
//   q_next, rem_next  : Q and A[N-1:0] as they will be after this iteration
//   m_zero            : divisor register holds zero
module divider_datapath #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         do_init,
  input  logic         do_shift,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] q_next,
  output logic [N-1:0] rem_next,
  output logic         m_zero
);

  logic [N:0]   a;
  logic [N-1:0] q;
  logic [N-1:0] m;

  logic [N+1:0] a_sh;
  logic         fits;
  logic [N:0]   a_next;

  // {A,Q} shifted left by one; the trial subtraction succeeds when the
  // shifted remainder is at least M, otherwise A is restored (kept as is).
  always_comb begin
    a_sh     = {a, q[N-1]};
    fits     = (a_sh >= {2'b00, m});
    a_next   = a_sh[N:0];
    q_next   = {q[N-2:0], 1'b0};
    if (fits) begin
      a_next = (N+1)'(a_sh - {2'b00, m});
      q_next = {q[N-2:0], 1'b1};
    end
    rem_next = a_next[N-1:0];
    m_zero   = (m == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      q <= '0;
      m <= '0;
    end else if (do_init) begin
      a <= '0;
      q <= dividend;
      m <= divisor;
    end else if (do_shift) begin
      a <= a_next;
      q <= q_next;
    end
  end

endmodule

// File: rtl/divider_unit.sv
// Multi-cycle unsigned divider (restoring algorithm), N iterations per result.
// Handshake: start is accepted on any rising edge where the unit is not busy
// (IDLE or DONE); operands are sampled on that edge only. start while busy is
// ignored. done pulses for one cycle with quotient/remainder/div_by_zero
// valid; those outputs hold until the next completion.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   start               : division request
//   dividend, divisor   : unsigned operands
//   busy                : iteration sequence in progress (RUN)
//   done                : one-cycle result pulse (DONE)
//   quotient, remainder : registered results
//   div_by_zero         : registered, result came from a zero divisor
//   dbg_state           : current FSM state for observation
module divider_unit
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output state_t       dbg_state
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          do_init;
  logic          do_shift;
  logic          last_iter;
  logic [N-1:0]  q_next;
  logic [N-1:0]  rem_next;
  logic          m_zero;

  divider_datapath #(.N(N)) u_dp (
    .clk      (clock),
    .reset    (reset),
    .do_init  (do_init),
    .do_shift (do_shift),
    .dividend (dividend),
    .divisor  (divisor),
    .q_next   (q_next),
    .rem_next (rem_next),
    .m_zero   (m_zero)
  );

  // The Nth iteration is the one executed while count still reads 1.
  assign last_iter = (state == RUN) && (count == CW'(1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RUN : IDLE;
      RUN:     state_nxt = last_iter ? DONE : RUN;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    do_init   = (state != RUN) && start;
    do_shift  = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    dbg_state = state;
  end

  always_ff @(posedge clock) begin
    if (reset)         count <= '0;
    else if (do_init)  count <= CW'(N);
    else if (do_shift) count <= count - CW'(1);
  end

  // Results are captured only on the completing edge, so the outputs never
  // show intermediate iteration values.
  always_ff @(posedge clock) begin
    if (reset) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (last_iter) begin
      quotient    <= q_next;
      remainder   <= rem_next;
      div_by_zero <= m_zero;
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
module tb_divider_unit;
  import divider_pkg::*;

  localparam int N = 4;
  localparam int RW = 2 * N + 1;   // {div_by_zero, remainder, quotient}

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  divider_unit #(.N(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [RW-1:0] ref_result(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] qv;
    logic [N-1:0] rv;
    if (b == 0) begin
      qv = '1;
      rv = a;
    end else begin
      qv = N'(a / b);
      rv = N'(a % b);
    end
    return {(b == 0), rv, qv};
  endfunction

  // Timing model: accept when not running, then N running cycles, then one
  // done cycle. Expected results are queued with the edge they complete on.
  logic [RW-1:0] exp_q[$];
  int            exp_t[$];
  int            edge_n   = 0;
  int            run_left = 0;
  bit            m_done   = 0;
  logic [RW-1:0] hold     = '0;

  always @(posedge clock) begin
    edge_n = edge_n + 1;
    if (reset) begin
      run_left = 0;
      m_done   = 0;
      hold     = '0;
      exp_q.delete();
      exp_t.delete();
    end else if (run_left > 0) begin
      run_left = run_left - 1;
      m_done   = (run_left == 0);
    end else begin
      m_done = 0;
      if (start) begin
        run_left = N;
        exp_q.push_back(ref_result(dividend, divisor));
        exp_t.push_back(edge_n + N);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [RW-1:0] e;
    chk("busy", busy, (run_left > 0));
    chk("done", done, m_done);
    if (run_left == 0 && !m_done) chk("state_idle", dbg_state, IDLE);
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_latency", edge_n, exp_t.pop_front());
        chk("quotient", quotient, e[N-1:0]);
        chk("remainder", remainder, e[2*N-1:N]);
        chk("div_by_zero", div_by_zero, e[2*N]);
        hold = e;
      end
    end else begin
      chk("hold_outputs", {div_by_zero, remainder, quotient}, hold);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clock); #1;
    reset = 1'b1;
    start = 1'b0;
    wait_edges(cycles);
    reset = 1'b0;
  endtask

  // Single start pulse, then wait out the operation and its done cycle.
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    wait_edges(1);
    start = 1'b0;
    wait_edges(N + 1);
  endtask

  // 13/3 with the per-iteration Q/A trace observed inside the datapath.
  task automatic op_trace();
    logic [N-1:0] q_tr[4];
    logic [N:0]   a_tr[4];
    q_tr = '{4'b1010, 4'b0101, 4'b1010, 4'b0100};
    a_tr = '{5'd1, 5'd0, 5'd0, 5'd1};
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    wait_edges(1);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("trace_q%0d", k + 1), dut.u_dp.q, q_tr[k]);
      chk($sformatf("trace_a%0d", k + 1), dut.u_dp.a, a_tr[k]);
    end
    wait_edges(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    wait_edges(2);
    @(negedge clock);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    op_trace();
    op(4'd11, 4'd6);
    op(4'd5,  4'd9);
    op(4'd7,  4'd0);
    op(4'd0,  4'd0);
    op(4'd15, 4'd15);
    op(4'd15, 4'd1);
    op(4'd0,  4'd7);

    // start held high, fresh operands every cycle: only DONE-cycle operands
    // are accepted, one result per N+1 cycles.
    start = 1'b1;
    for (int i = 0; i < 6 * (N + 1); i++) begin
      dividend = N'($urandom_range(0, (1 << N) - 1));
      divisor  = N'($urandom_range(0, (1 << N) - 1));
      wait_edges(1);
    end
    start = 1'b0;
    wait_edges(N + 2);

    // Abort 13/3 at iteration 2, then 15/4.
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    wait_edges(1);
    start = 1'b0;
    wait_edges(1);
    reset = 1'b1;
    wait_edges(1);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_state", dbg_state, IDLE);
    chk("abort_quotient", quotient, 0);
    @(posedge clock); #1;
    op(4'd15, 4'd4);
    chk("post_abort_q", quotient, 3);
    chk("post_abort_r", remainder, 3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 2) == 0);
      dividend = N'($urandom_range(0, (1 << N) - 1));
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      reset    = ($urandom_range(0, 99) == 0);
      wait_edges(1);
    end
    start = 1'b0;
    reset = 1'b0;

    // Drain with a bounded wait.
    for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) wait_edges(1);
    wait_edges(2);
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter: N, default 4, operand/result width in bits; SHALL support N >= 2.
REQ-002 clock  input  1  rising-edge clock; sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on clock rising edge.
REQ-004 start  input  1  request a division; sampled each rising edge.
REQ-005 dividend  input  N  unsigned dividend; sampled only on the edge that accepts start.
REQ-006 divisor  input  N  unsigned divisor; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while an iteration sequence is in progress.
REQ-008 done  output  1  single-cycle pulse; quotient/remainder/div_by_zero valid.
REQ-009 quotient  output  N  registered result, floor(dividend/divisor).
REQ-010 remainder  output  N  registered result, dividend mod divisor.
REQ-011 div_by_zero  output  1  registered; high when the result's divisor was 0.

Function
REQ-012 Algorithm SHALL be restoring shift-subtract: partial remainder A (N+1 bits), shift register Q (N bits), divisor register M (N bits), iteration counter.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 at an edge: A<=0, Q<=dividend, M<=divisor, count<=N, next state RUN.
REQ-015 DONE with start=0: next state IDLE; IDLE with start=0: stay IDLE.
REQ-016 RUN, each edge: {A,Q} shifted left one bit; trial T = A_shifted - {0,M}; T>=0 -> A<=T, Q[0]<=1; else A unchanged (restored), Q[0]<=0; count decrements.
REQ-017 RUN SHALL perform exactly N iterations, then enter DONE on the edge completing the Nth iteration.
REQ-018 On that same edge quotient<=final Q, remainder<=final A[N-1:0], div_by_zero<=(M==0).
REQ-019 Latency: start accepted at edge E -> busy high E+1..E+N (exclusive of DONE), done high for exactly the cycle after edge E+N.
REQ-020 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-021 start in RUN SHALL be ignored; the operation in progress is unaffected.
REQ-022 start in DONE SHALL be accepted (back-to-back operation, no idle cycle required).
REQ-023 quotient, remainder, div_by_zero SHALL hold their last values until the next completion; they SHALL NOT show intermediate values.
REQ-024 Divisor 0: no special path; algorithm yields quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-025 Dividend < divisor: quotient=0, remainder=dividend.

Reset
REQ-026 reset=1 at an edge SHALL force state IDLE, A, Q, M, count, quotient, remainder to 0 and div_by_zero, busy, done to 0.
REQ-027 reset SHALL take priority over start and over any RUN iteration; an aborted operation SHALL produce no done pulse and no result update.
REQ-028 First edge with reset=0 SHALL behave as IDLE (start accepted on that edge).

Structure
REQ-029 Shared package divider_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default width constant.
REQ-030 Datapath (A, Q, M, subtractor) SHALL be a sub-module divider_datapath with control inputs do_init and do_shift, driven by the FSM in divider_unit.
REQ-031 Counter width SHALL be $clog2(N+1) bits.

Verification
REQ-032 reset held 2 cycles -> all outputs 0, busy=0, done=0.
REQ-033 N=4, dividend=13, divisor=3, start 1 cycle -> after iterations Q=1010,0101,1010,0100 / A=1,0,0,1; done pulse N+1 cycles after start edge; quotient=4, remainder=1, div_by_zero=0.
REQ-034 dividend=11, divisor=6 -> quotient=1, remainder=5; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-035 dividend=7, divisor=0 -> quotient=15, remainder=7, div_by_zero=1.
REQ-036 start held high continuously with new operands each DONE cycle -> one result every N+1 cycles; start pulses during RUN ignored, outputs unchanged until done.
REQ-037 reset asserted at iteration 2 of 13/3 -> no done pulse, outputs 0, IDLE next cycle; subsequent 15/4 -> quotient=3, remainder=3.
